ascon_bdi_packer: RTL
=====================

Name: ascon_bdi_packer

Overview:
- Upstream stage of the Ascon core: packs a byte-wide input stream into CCW-bit bdi words.
- Drives the core's bdi/bdi_valid/bdi_type/bdi_eot/bdi_eoi interface and honours bdi_ready.
- Partial final words of a segment carry a byte-valid mask. The core pads them.
- Two-deep buffering (accumulator plus output register), so packing continues while the core is stalled.

Parameters:
CCW, 32, core word width in bits; 32 or 64; CCW/8 = bytes per word (BPW)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
in_data  in  8  input byte
in_valid  in  1  byte valid
in_ready  out  1  byte accepted when in_valid && in_ready
in_type  in  e_data_type  segment type of the byte (D_NONCE, D_AD, D_MSG, D_TAG)
in_last  in  1  byte is last of its segment
in_eoi  in  1  byte is last of the whole input; only meaningful with in_last
bdi  out  CCW  packed word; first byte of the word in bits [7:0]
bdi_valid  out  CCW/8  byte-valid mask, contiguous from bit 0; 0 = no word
bdi_ready  in  1  core accepts word when bdi_valid != 0 && bdi_ready
bdi_type  out  e_data_type  type of the current word; D_NULL when bdi_valid == 0
bdi_eot  out  1  word ends its segment
bdi_eoi  out  1  word ends the input
err  out  1  sticky protocol error flag

Behaviour:
- Reset: all outputs 0, bdi_type = D_NULL, in_ready = 0 while rst is high, accumulator and output register empty, err = 0. Reset mid-word discards partial data.
- Accumulator state:
  - byte count cnt (0..BPW-1), data register, latched type, last/eoi flags, acc_full bit.
  - in_ready = !rst && !acc_full.
- Byte accept:
  - Byte is written to lane cnt (bits [8*cnt+7 : 8*cnt]).
  - Type is latched when cnt == 0.
  - If cnt == BPW-1 or in_last, the word is complete: cnt <= 0, acc_full <= 1, and last/eoi are recorded.
  - Otherwise cnt <= cnt + 1.
- in_eoi without in_last: treated as in_last = 1 and err set.
- Type mismatch with the latched type while cnt != 0: byte still accepted and err set.
- Transfer rule: a complete accumulator moves to the output register in the same cycle it becomes complete, when out_empty || (bdi_valid != 0 && bdi_ready).
  - Mask = (1 << n) - 1, where n is the number of bytes written.
  - Unused lanes of bdi are 0.
  - Otherwise acc_full holds and in_ready drops until transfer.
- Latency: word-completing byte accepted at edge t → bdi_valid != 0 from t+1, if the output register was free.
- Throughput: 1 byte/cycle sustained while the core accepts every word within BPW cycles.
- Output register:
  - Holds bdi/bdi_valid/bdi_type/eot/eoi stable until bdi_ready.
  - On acceptance with no pending accumulator it clears to bdi_valid = 0, bdi_type = D_NULL.
  - Simultaneous accept and new transfer loads the new word with no bubble.
- Full stall: when the output register is held and the accumulator is full, in_ready = 0 and no byte is lost or duplicated.
- Segment boundary: each in_last closes the word even when cnt < BPW-1, so a word never mixes segments.
- bdi_eot = in_last of its final byte; bdi_eoi = in_eoi of its final byte.
- Zero-length segments are not representable. The producer signals empty input via the core's mode path, not this block.
- err clears only on rst.

Test Plan:
- CCW=32; bytes 01..08 type D_AD, in_last on 08 → two words, bdi=0x04030201 then 0x08070605, bdi_valid=4'hF both, eot=0 then 1, type D_AD.
- 6 bytes AA..FF type D_MSG, in_last+in_eoi on last byte → word1 0xDDCCBBAA mask F; word2 0x0000FFEE mask 4'h3, eot=1, eoi=1.
- Hold bdi_ready=0 while streaming 12 bytes → first word stable, accumulator fills, in_ready=0 after the 8th byte; release → words 1..3 delivered in order with no loss or duplicates.
- Back-to-back D_AD (3 bytes, last) then D_MSG (4 bytes) → AD word mask 4'h7 eot=1; MSG word mask F type D_MSG; 1-byte/cycle input with no in_ready gap when bdi_ready=1.
- Type change mid-word, and in_eoi without in_last → err=1 sticky; words still emitted.
- Assert rst after 2 bytes of a word, then send 4 new bytes → outputs 0/D_NULL during reset; the next word contains only the new bytes, mask F.

Source files
------------

// File: rtl/ascon_bdi_packer.sv
// Byte-to-word packer feeding the Ascon core bdi interface.
// Holds one word in an accumulator and one in an output register, so input keeps flowing while the core stalls.
package ascon_bdi_pkg;
    typedef enum logic [2:0] {
        D_NULL  = 3'd0,
        D_NONCE = 3'd1,
        D_AD    = 3'd2,
        D_MSG   = 3'd3,
        D_TAG   = 3'd4
    } e_data_type;
endpackage

module ascon_bdi_packer
    import ascon_bdi_pkg::*;
#(
    parameter int CCW = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [7:0]           in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  e_data_type           in_type,
    input  logic                 in_last,
    input  logic                 in_eoi,
    output logic [CCW-1:0]       bdi,
    output logic [CCW/8-1:0]     bdi_valid,
    input  logic                 bdi_ready,
    output e_data_type           bdi_type,
    output logic                 bdi_eot,
    output logic                 bdi_eoi,
    output logic                 err
);

    localparam int BPW   = CCW / 8;
    localparam int CNT_W = $clog2(BPW);
    localparam int N_W   = CNT_W + 1;

    // Contiguous byte-valid mask with the lowest n lanes set.
    function automatic logic [BPW-1:0] mask_of(input logic [N_W-1:0] n);
        logic [BPW-1:0] m;
        for (int i = 0; i < BPW; i++) begin
            if (i < int'(n)) begin
                m[i] = 1'b1;
            end else begin
                m[i] = 1'b0;
            end
        end
        return m;
    endfunction

    logic [CNT_W-1:0] cnt_r;
    logic [CCW-1:0]   data_r;
    logic [N_W-1:0]   n_r;
    e_data_type       type_r;
    logic             last_r;
    logic             eoi_r;
    logic             acc_full_r;

    logic [CCW-1:0]   bdi_r;
    logic [BPW-1:0]   bdi_valid_r;
    e_data_type       bdi_type_r;
    logic             bdi_eot_r;
    logic             bdi_eoi_r;
    logic             err_r;

    logic             in_ready_s;
    logic             accept_s;
    logic             eff_last_s;
    logic             complete_s;
    logic             out_busy_s;
    logic             out_free_s;
    logic             transfer_s;
    logic             proto_err_s;
    logic [CCW-1:0]   data_merge_s;
    logic [CCW-1:0]   src_data_s;
    logic [N_W-1:0]   src_n_s;
    e_data_type       src_type_s;
    logic             src_last_s;
    logic             src_eoi_s;

    assign in_ready_s  = !rst && !acc_full_r;
    assign accept_s    = in_valid && in_ready_s;
    // in_eoi alone still has to close the word, otherwise the core would never see the end of input.
    assign eff_last_s  = in_last || in_eoi;
    assign complete_s  = accept_s && ((cnt_r == CNT_W'(BPW - 1)) || eff_last_s);
    assign out_busy_s  = (bdi_valid_r != {BPW{1'b0}});
    assign out_free_s  = !out_busy_s || bdi_ready;
    assign transfer_s  = (acc_full_r || complete_s) && out_free_s;
    assign proto_err_s = accept_s &&
                         ((in_eoi && !in_last) ||
                          ((cnt_r != {CNT_W{1'b0}}) && (in_type != type_r)));

    // Accumulator contents with the incoming byte dropped into lane cnt.
    always_comb begin
        data_merge_s = data_r;
        for (int lane = 0; lane < BPW; lane++) begin
            if (cnt_r == CNT_W'(lane)) begin
                data_merge_s[8*lane +: 8] = in_data;
            end else begin
                data_merge_s[8*lane +: 8] = data_r[8*lane +: 8];
            end
        end
    end

    // Word offered to the output register: a parked full word, or the one completing this cycle.
    always_comb begin
        src_data_s = data_r;
        src_n_s    = n_r;
        src_type_s = type_r;
        src_last_s = last_r;
        src_eoi_s  = eoi_r;
        if (acc_full_r) begin
            src_data_s = data_r;
            src_n_s    = n_r;
            src_type_s = type_r;
            src_last_s = last_r;
            src_eoi_s  = eoi_r;
        end else begin
            src_data_s = data_merge_s;
            src_n_s    = {1'b0, cnt_r} + N_W'(1);
            if (cnt_r == {CNT_W{1'b0}}) begin
                src_type_s = in_type;
            end else begin
                src_type_s = type_r;
            end
            src_last_s = eff_last_s;
            src_eoi_s  = in_eoi;
        end
    end

    // Accumulator: collects bytes, parks a complete word while the output register is occupied.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r      <= {CNT_W{1'b0}};
            data_r     <= {CCW{1'b0}};
            n_r        <= {N_W{1'b0}};
            type_r     <= D_NULL;
            last_r     <= 1'b0;
            eoi_r      <= 1'b0;
            acc_full_r <= 1'b0;
        end else if (transfer_s) begin
            cnt_r      <= {CNT_W{1'b0}};
            data_r     <= {CCW{1'b0}};
            n_r        <= {N_W{1'b0}};
            type_r     <= D_NULL;
            last_r     <= 1'b0;
            eoi_r      <= 1'b0;
            acc_full_r <= 1'b0;
        end else if (complete_s) begin
            cnt_r      <= {CNT_W{1'b0}};
            data_r     <= src_data_s;
            n_r        <= src_n_s;
            type_r     <= src_type_s;
            last_r     <= src_last_s;
            eoi_r      <= src_eoi_s;
            acc_full_r <= 1'b1;
        end else if (accept_s) begin
            cnt_r  <= cnt_r + CNT_W'(1);
            data_r <= data_merge_s;
            if (cnt_r == {CNT_W{1'b0}}) begin
                type_r <= in_type;
            end else begin
                type_r <= type_r;
            end
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Output register: stable until the core takes it, reloaded in the same cycle when a word is ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            bdi_r       <= {CCW{1'b0}};
            bdi_valid_r <= {BPW{1'b0}};
            bdi_type_r  <= D_NULL;
            bdi_eot_r   <= 1'b0;
            bdi_eoi_r   <= 1'b0;
        end else if (transfer_s) begin
            bdi_r       <= src_data_s;
            bdi_valid_r <= mask_of(src_n_s);
            bdi_type_r  <= src_type_s;
            bdi_eot_r   <= src_last_s;
            bdi_eoi_r   <= src_eoi_s;
        end else if (out_busy_s && bdi_ready) begin
            bdi_r       <= {CCW{1'b0}};
            bdi_valid_r <= {BPW{1'b0}};
            bdi_type_r  <= D_NULL;
            bdi_eot_r   <= 1'b0;
            bdi_eoi_r   <= 1'b0;
        end else begin
            bdi_valid_r <= bdi_valid_r;
        end
    end

    // Sticky protocol error, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_r <= 1'b0;
        end else if (proto_err_s) begin
            err_r <= 1'b1;
        end else begin
            err_r <= err_r;
        end
    end

    assign in_ready  = in_ready_s;
    assign bdi       = bdi_r;
    assign bdi_valid = bdi_valid_r;
    assign bdi_type  = bdi_type_r;
    assign bdi_eot   = bdi_eot_r;
    assign bdi_eoi   = bdi_eoi_r;
    assign err       = err_r;

endmodule
